clkfx_ce_synth: RTL and testbench

//  Synthesisable, parametrised successor to the behavioural CLKFX clock model.

---
 rtl/clkfx_ce_synth.sv | 131 +++++++++++++
 tb/tb_clkfx_ce_synth.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/clkfx_ce_synth.sv
// Rational-rate clock-enable generator: a Bresenham accumulator emits M enables per D cycles,
// plus a half-period-offset enable, a level output, lock sequencing and a phase-shift handshake.
module clkfx_ce_synth #(
  parameter int unsigned CLKFX_MULTIPLY = 2,
  parameter int unsigned CLKFX_DIVIDE   = 3,
  parameter int unsigned ACC_W          = 16,
  parameter int unsigned LOCK_CYCLES    = 16,
  parameter int unsigned PS_STEP        = 1
) (
  input  logic       CLKIN,
  input  logic       RST,
  input  logic       EN,
  input  logic       PSEN,
  input  logic       PSINCDEC,
  output logic       CLKFX_EN,
  output logic       CLKFX180_EN,
  output logic       CLKFX_LVL,
  output logic       LOCKED,
  output logic       PSDONE,
  output logic [2:0] STATUS
);

  localparam int unsigned CntW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef logic [ACC_W-1:0] acc_t;
  typedef logic [ACC_W:0]   sum_t;
  typedef logic [CntW-1:0]  cnt_t;
  typedef enum logic {StSettle, StLock} state_e;

  localparam sum_t StepNom  = sum_t'(CLKFX_MULTIPLY);
  localparam sum_t StepInc  = sum_t'(CLKFX_MULTIPLY + PS_STEP);
  localparam sum_t StepDec  = sum_t'(CLKFX_MULTIPLY - PS_STEP);
  localparam sum_t DivS     = sum_t'(CLKFX_DIVIDE);
  localparam sum_t HalfS    = sum_t'(CLKFX_DIVIDE / 2);
  localparam sum_t DivHalfS = sum_t'(CLKFX_DIVIDE + CLKFX_DIVIDE / 2);
  localparam cnt_t CntLast  = cnt_t'(LOCK_CYCLES - 1);

  acc_t   acc_q, acc_d;
  cnt_t   cnt_q, cnt_d;
  state_e state_q, state_d;
  logic   fx_q, fx_d;
  logic   h_q, h_d;
  logic   lvl_q, lvl_d;
  logic   psdone_q, psdone_d;
  logic   rej_q, rej_d;
  logic   nen_q, nen_d;

  logic   ps_accept;
  sum_t   step;
  sum_t   sum;
  logic   fx_hit;
  logic   h_hit;

  always_comb begin
    // A pending PSDONE keeps the handshake busy, so a request on that cycle is refused.
    ps_accept = PSEN & EN & (state_q == StLock) & ~psdone_q;
    step      = StepNom;
    if (ps_accept) begin
      step = PSINCDEC ? StepInc : StepDec;
    end
    sum    = sum_t'(acc_q) + step;
    fx_hit = (sum >= DivS);
    h_hit  = ((sum_t'(acc_q) < HalfS) && (sum >= HalfS)) || (sum >= DivHalfS);

    acc_d    = acc_q;
    cnt_d    = cnt_q;
    state_d  = state_q;
    fx_d     = 1'b0;
    h_d      = 1'b0;
    lvl_d    = lvl_q;
    psdone_d = ps_accept;
    rej_d    = rej_q | (PSEN & ~ps_accept);
    nen_d    = ~EN;

    if (!EN) begin
      cnt_d   = '0;
      state_d = StSettle;
      lvl_d   = 1'b0;
    end else begin
      acc_d = fx_hit ? acc_t'(sum - DivS) : acc_t'(sum);
      if (state_q == StSettle) begin
        lvl_d = 1'b0;
        if (cnt_q == CntLast) begin
          state_d = StLock;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end else begin
        fx_d = fx_hit;
        h_d  = h_hit;
        if (fx_hit) begin
          lvl_d = 1'b1;
        end else if (h_hit) begin
          lvl_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge CLKIN) begin
    if (RST) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      state_q  <= StSettle;
      fx_q     <= 1'b0;
      h_q      <= 1'b0;
      lvl_q    <= 1'b0;
      psdone_q <= 1'b0;
      rej_q    <= 1'b0;
      nen_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      fx_q     <= fx_d;
      h_q      <= h_d;
      lvl_q    <= lvl_d;
      psdone_q <= psdone_d;
      rej_q    <= rej_d;
      nen_q    <= nen_d;
    end
  end

  assign CLKFX_EN    = fx_q;
  assign CLKFX180_EN = h_q;
  assign CLKFX_LVL   = lvl_q;
  assign LOCKED      = (state_q == StLock);
  assign PSDONE      = psdone_q;
  assign STATUS      = {1'b0, nen_q, rej_q};

endmodule

// File: tb/tb_clkfx_ce_synth.sv
// Scoreboard bench: three configurations share one random stimulus stream; a phase-position
// model predicts every registered output, and a monitor compares each cycle.
module tb_clkfx_ce_synth;

  typedef struct packed {
    logic       fx;
    logic       h;
    logic       lvl;
    logic       locked;
    logic       psdone;
    logic [2:0] status;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic psen = 1'b0;
  logic psincdec = 1'b0;

  always #5 clk = ~clk;

  logic [2:0] fx, h, lvl, lk, pd;
  logic [2:0] st [3];

  clkfx_ce_synth #(.CLKFX_MULTIPLY(2), .CLKFX_DIVIDE(3), .ACC_W(16), .LOCK_CYCLES(16),
                   .PS_STEP(1)) u_a (
    .CLKIN(clk), .RST(rst), .EN(en), .PSEN(psen), .PSINCDEC(psincdec),
    .CLKFX_EN(fx[0]), .CLKFX180_EN(h[0]), .CLKFX_LVL(lvl[0]), .LOCKED(lk[0]),
    .PSDONE(pd[0]), .STATUS(st[0])
  );

  clkfx_ce_synth #(.CLKFX_MULTIPLY(1), .CLKFX_DIVIDE(4), .ACC_W(8), .LOCK_CYCLES(16),
                   .PS_STEP(1)) u_b (
    .CLKIN(clk), .RST(rst), .EN(en), .PSEN(psen), .PSINCDEC(psincdec),
    .CLKFX_EN(fx[1]), .CLKFX180_EN(h[1]), .CLKFX_LVL(lvl[1]), .LOCKED(lk[1]),
    .PSDONE(pd[1]), .STATUS(st[1])
  );

  clkfx_ce_synth #(.CLKFX_MULTIPLY(3), .CLKFX_DIVIDE(3), .ACC_W(8), .LOCK_CYCLES(1),
                   .PS_STEP(0)) u_c (
    .CLKIN(clk), .RST(rst), .EN(en), .PSEN(psen), .PSINCDEC(psincdec),
    .CLKFX_EN(fx[2]), .CLKFX180_EN(h[2]), .CLKFX_LVL(lvl[2]), .LOCKED(lk[2]),
    .PSDONE(pd[2]), .STATUS(st[2])
  );

  int mm [3] = '{2, 1, 3};
  int dd [3] = '{3, 4, 3};
  int pss[3] = '{1, 1, 0};
  int lkc[3] = '{16, 16, 1};

  // Expected enable counts over a 3000-cycle locked window.
  int exp_wfx [3] = '{2000, 750, 3000};
  int exp_wh  [3] = '{2000, 750, 3000};
  int exp_wlvl[3] = '{2000, 1500, 3000};

  int checks = 0;
  int errors = 0;

  longint pos[3];
  int     run[3];
  out_t   cur[3];
  out_t   q0[$], q1[$], q2[$];

  bit win = 1'b0;
  int wfx[3], wh[3], wlvl[3];

  // pos is the total accumulated phase; enables fire when it crosses k*D (fx) or k*D+H (h).
  function automatic out_t model_step(int i, logic r, logic e, logic p, logic inc);
    out_t   c = cur[i];
    out_t   n = '0;
    logic   acc;
    longint stp, hh, nfx, nh;
    if (!r) begin
      n.status[1] = !e;
      acc         = p && e && c.locked && !c.psdone;
      n.status[0] = c.status[0] | (p & !acc);
      n.psdone    = acc;
      if (!e) begin
        run[i] = 0;
      end else begin
        stp = mm[i];
        if (acc) stp = inc ? stp + pss[i] : stp - pss[i];
        hh  = dd[i] / 2;
        nfx = (pos[i] + stp) / dd[i] - pos[i] / dd[i];
        nh  = (pos[i] + stp + dd[i] - hh) / dd[i] - (pos[i] + dd[i] - hh) / dd[i];
        if (c.locked) begin
          n.fx  = (nfx > 0);
          n.h   = (nh > 0);
          n.lvl = n.fx ? 1'b1 : (n.h ? 1'b0 : c.lvl);
        end
        pos[i]   = pos[i] + stp;
        run[i]   = run[i] + 1;
        n.locked = (run[i] >= lkc[i]);
      end
    end else begin
      pos[i] = 0;
      run[i] = 0;
    end
    cur[i] = n;
    return n;
  endfunction

  task automatic drive(input logic r, input logic e, input logic p, input logic inc);
    @(negedge clk);
    rst      = r;
    en       = e;
    psen     = p;
    psincdec = inc;
    q0.push_back(model_step(0, r, e, p, inc));
    q1.push_back(model_step(1, r, e, p, inc));
    q2.push_back(model_step(2, r, e, p, inc));
  endtask

  function automatic out_t dut_out(int i);
    out_t o;
    o = {fx[i], h[i], lvl[i], lk[i], pd[i], st[i]};
    return o;
  endfunction

  task automatic compare(input int i, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL outputs inst%0d t=%0t: got fx=%b h=%b lvl=%b lock=%b psdone=%b st=%b, want fx=%b h=%b lvl=%b lock=%b psdone=%b st=%b",
               i, $time, got.fx, got.h, got.lvl, got.locked, got.psdone, got.status,
               exp.fx, exp.h, exp.lvl, exp.locked, exp.psdone, exp.status);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, exp);
    end
  endtask

  // Monitor: every output cycle pops one prediction per instance.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) compare(0, dut_out(0), q0.pop_front());
      if (q1.size() > 0) compare(1, dut_out(1), q1.pop_front());
      if (q2.size() > 0) compare(2, dut_out(2), q2.pop_front());
      if (win) begin
        for (int i = 0; i < 3; i++) begin
          wfx[i]  += int'(fx[i]);
          wh[i]   += int'(h[i]);
          wlvl[i] += int'(lvl[i]);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      pos[i] = 0; run[i] = 0; cur[i] = '0; wfx[i] = 0; wh[i] = 0; wlvl[i] = 0;
    end

    repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (40) drive(1'b0, 1'b1, 1'b0, 1'b0);

    win = 1'b1;
    repeat (3000) drive(1'b0, 1'b1, 1'b0, 1'b0);
    win = 1'b0;
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      check_int($sformatf("window fx count inst%0d", i), wfx[i], exp_wfx[i]);
      check_int($sformatf("window h count inst%0d", i), wh[i], exp_wh[i]);
      check_int($sformatf("window lvl count inst%0d", i), wlvl[i], exp_wlvl[i]);
    end

    // Advance, then a second request on the PSDONE cycle which must be refused.
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (10) drive(1'b0, 1'b1, 1'b0, 1'b0);

    repeat (5) drive(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (30) drive(1'b0, 1'b1, 1'b0, 1'b0);

    repeat (2000) begin
      drive(logic'($urandom_range(0, 399) == 0), logic'($urandom_range(0, 49) != 0),
            logic'($urandom_range(0, 5) == 0), logic'($urandom_range(0, 1)));
    end

    // Reset while PSDONE is pending.
    repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 100 && !cur[0].locked; k++) drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, logic'($urandom_range(0, 1)));
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (20) drive(1'b0, 1'b1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    check_int("scoreboard drained", q0.size() + q1.size() + q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
